regwb_arbiter: RTL and testbench

//  Shares the single general-register write port between the in-order pipeline writeback (port A)
//  and a multi-cycle unit such as the divider (port B). A always wins. B results are buffered in a

---
 rtl/regwb_arbiter_if.sv | 35 +++
 rtl/regwb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regwb_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/regwb_arbiter_if.sv
// Write-port sharing bus between the pipeline (A), the multi-cycle unit (B), decode lookups and the register file.
// The slave modport is the arbiter side; the master modport is the surrounding core/bench side.
interface regwb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic                       flush;
  logic                       a_we;
  logic [AW-1:0]              a_waddr;
  logic [DW-1:0]              a_wdata;
  logic                       b_valid;
  logic                       b_ready;
  logic [AW-1:0]              b_waddr;
  logic [DW-1:0]              b_wdata;
  logic [AW-1:0]              lu_addr_1;
  logic [AW-1:0]              lu_addr_2;
  logic                       pend_hit_1;
  logic                       pend_hit_2;
  logic                       rf_we;
  logic [AW-1:0]              rf_waddr;
  logic [DW-1:0]              rf_wdata;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       stall_req;

  modport slave (
    input  flush, a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, lu_addr_1, lu_addr_2,
    output b_ready, pend_hit_1, pend_hit_2, rf_we, rf_waddr, rf_wdata, fifo_count, stall_req
  );

  modport master (
    output flush, a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, lu_addr_1, lu_addr_2,
    input  b_ready, pend_hit_1, pend_hit_2, rf_we, rf_waddr, rf_wdata, fifo_count, stall_req
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) always wins, multi-cycle results (B) buffered in a FIFO.
// Optional starve guard enabled by defining REGWB_STARVE_GUARD_EN.
module regwb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             rst_n,
  regwb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] vld_all;
  logic [AW-1:0]    addr_all [DEPTH];
  logic [DW-1:0]    data_all [DEPTH];
  logic [DEPTH-1:0] hit1_vec;
  logic [DEPTH-1:0] hit2_vec;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_en_q;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic          a_act;
  logic          head_present;
  logic          head_vld;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          push;
  logic          pop;
  logic          b_grant;

  // Writes to address 0 are architecturally void, so A to r0 counts as idle.
  assign a_act        = bus.a_we && (bus.a_waddr != '0);
  assign head_present = (cnt_q != '0);
  assign head_vld     = vld_all[rd_ptr_q];
  assign head_addr    = addr_all[rd_ptr_q];
  assign head_data    = data_all[rd_ptr_q];

  assign bus.b_ready = rdy_en_q && (cnt_q < FULL_CNT) && !bus.flush;
  assign push        = bus.b_valid && bus.b_ready && (bus.b_waddr != '0);
  assign b_grant     = head_present && head_vld && !a_act && !bus.flush;
  // A squashed head leaves the FIFO even while A owns the port.
  assign pop         = head_present && (b_grant || !head_vld);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic          vld_q, vld_d;
      logic [AW-1:0] addr_q, addr_d;
      logic [DW-1:0] data_q, data_d;

      // Order matters: squash/pop first, then a fresh push to this slot, flush overrides all.
      always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (a_act && (addr_q == bus.a_waddr)) vld_d = 1'b0;
        if (pop && (rd_ptr_q == PW'(gi)))     vld_d = 1'b0;
        if (push && (wr_ptr_q == PW'(gi))) begin
          vld_d  = 1'b1;
          addr_d = bus.b_waddr;
          data_d = bus.b_wdata;
        end
        if (bus.flush) vld_d = 1'b0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
        end else begin
          vld_q  <= vld_d;
          addr_q <= addr_d;
          data_q <= data_d;
        end
      end

      assign vld_all[gi]  = vld_q;
      assign addr_all[gi] = addr_q;
      assign data_all[gi] = data_q;
      assign hit1_vec[gi] = vld_q && (addr_q == bus.lu_addr_1);
      assign hit2_vec[gi] = vld_q && (addr_q == bus.lu_addr_2);
    end
  endgenerate

  assign bus.pend_hit_1 = (|hit1_vec) && (bus.lu_addr_1 != '0);
  assign bus.pend_hit_2 = (|hit2_vec) && (bus.lu_addr_2 != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (a_act) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.a_waddr;
      rf_wdata_d = bus.a_wdata;
    end else if (b_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rdy_en_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rdy_en_q   <= 1'b1;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_count = cnt_q;

`ifdef REGWB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  // Counts cycles a live head loses to A; the stall request holds until B gets the port.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (bus.flush || b_grant || !head_present) begin
      starve_d = '0;
    end else if (head_vld && a_act && (starve_q != LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    if (bus.flush || b_grant) begin
      stall_d = 1'b0;
    end else if (starve_q == LIMIT) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.stall_req = stall_q;
`else
  assign bus.stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed, table-driven bench for regwb_arbiter plus hand-written starve-guard and async-reset sequences.
// Honours REGWB_STARVE_GUARD_EN for the expected stall_req value.
module tb_regwb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef REGWB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regwb_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  regwb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_v;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          fl;
    logic [AW-1:0] lu1;
    logic [AW-1:0] lu2;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [2:0]    e_cnt;
    logic          e_rdy;
    logic          e_p1;
    logic          e_p2;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    input logic a_we, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
    input logic b_v, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data,
    input logic fl, input logic [AW-1:0] lu1, input logic [AW-1:0] lu2,
    input logic e_we, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
    input logic [2:0] e_cnt, input logic e_rdy, input logic e_p1, input logic e_p2);
    vec_t v;
    v.a_we = a_we; v.a_addr = a_addr; v.a_data = a_data;
    v.b_v = b_v; v.b_addr = b_addr; v.b_data = b_data;
    v.fl = fl; v.lu1 = lu1; v.lu2 = lu2;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_p1 = e_p1; v.e_p2 = e_p2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_we      = v.a_we;
    bus.a_waddr   = v.a_addr;
    bus.a_wdata   = v.a_data;
    bus.b_valid   = v.b_v;
    bus.b_waddr   = v.b_addr;
    bus.b_wdata   = v.b_data;
    bus.flush     = v.fl;
    bus.lu_addr_1 = v.lu1;
    bus.lu_addr_2 = v.lu2;
  endtask

  initial begin
    vec_t idle;
    rst_n = 1'b0;
    idle  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    drive(idle);

    //            a_we addr data          b_v addr data         fl lu1 lu2 | we addr data        cnt rdy p1 p2
    vecs[0]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,    0, 0,  32'h0,        0, 1, 0, 0);
    vecs[1]  = mk(1, 5,  32'h12345678, 0, 0,  32'h0,        0, 0,  0,    1, 5,  32'h12345678, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,    0, 5,  32'h12345678, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0,  32'h0,        1, 9,  32'hDEADBEEF, 0, 9,  0,    0, 5,  32'h12345678, 1, 1, 1, 0);
    vecs[4]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 9,  0,    1, 9,  32'hDEADBEEF, 0, 1, 0, 0);
    vecs[5]  = mk(1, 10, 32'hA0,       1, 20, 32'h20,       0, 20, 23,   1, 10, 32'hA0,       1, 1, 1, 0);
    vecs[6]  = mk(1, 11, 32'hA1,       1, 21, 32'h21,       0, 20, 23,   1, 11, 32'hA1,       2, 1, 1, 0);
    vecs[7]  = mk(1, 12, 32'hA2,       1, 22, 32'h22,       0, 20, 23,   1, 12, 32'hA2,       3, 1, 1, 0);
    vecs[8]  = mk(1, 13, 32'hA3,       1, 23, 32'h23,       0, 20, 23,   1, 13, 32'hA3,       4, 0, 1, 1);
    vecs[9]  = mk(0, 0,  32'h0,        1, 24, 32'h24,       0, 20, 24,   1, 20, 32'h20,       3, 1, 0, 0);
    vecs[10] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 21, 23,   1, 21, 32'h21,       2, 1, 0, 1);
    vecs[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 23, 22,   1, 22, 32'h22,       1, 1, 1, 0);
    vecs[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 23, 0,    1, 23, 32'h23,       0, 1, 0, 0);
    vecs[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,    0, 23, 32'h23,       0, 1, 0, 0);
    vecs[14] = mk(0, 0,  32'h0,        1, 7,  32'h7,        0, 7,  0,    0, 23, 32'h23,       1, 1, 1, 0);
    vecs[15] = mk(0, 0,  32'h0,        1, 8,  32'h8,        0, 7,  8,    1, 7,  32'h7,        1, 1, 0, 1);
    vecs[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  8,    1, 8,  32'h8,        0, 1, 0, 0);
    vecs[17] = mk(1, 0,  32'hFF,       1, 0,  32'hEE,       0, 0,  0,    0, 8,  32'h8,        0, 1, 0, 0);
    vecs[18] = mk(0, 0,  32'h0,        1, 3,  32'h33,       0, 3,  0,    0, 8,  32'h8,        1, 1, 1, 0);
    vecs[19] = mk(1, 3,  32'h1,        0, 0,  32'h0,        0, 3,  0,    1, 3,  32'h1,        1, 1, 0, 0);
    vecs[20] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 3,  0,    0, 3,  32'h1,        0, 1, 0, 0);
    vecs[21] = mk(1, 6,  32'h66,       1, 6,  32'h77,       0, 6,  0,    1, 6,  32'h66,       1, 1, 1, 0);
    vecs[22] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 6,  0,    1, 6,  32'h77,       0, 1, 0, 0);
    vecs[23] = mk(1, 30, 32'hC0,       1, 1,  32'h11,       0, 1,  4,    1, 30, 32'hC0,       1, 1, 1, 0);
    vecs[24] = mk(1, 30, 32'hC1,       1, 2,  32'h22,       0, 1,  4,    1, 30, 32'hC1,       2, 1, 1, 0);
    vecs[25] = mk(1, 30, 32'hC2,       1, 4,  32'h44,       0, 1,  4,    1, 30, 32'hC2,       3, 1, 1, 1);
    vecs[26] = mk(1, 31, 32'hAB,       0, 0,  32'h0,        1, 1,  4,    1, 31, 32'hAB,       0, 0, 0, 0);
    vecs[27] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 1,  4,    0, 31, 32'hAB,       0, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we",    32'(bus.rf_we),      32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr),   32'd0);
    chk("rst_rf_wdata", bus.rf_wdata,        32'd0);
    chk("rst_count",    32'(bus.fifo_count), 32'd0);
    chk("rst_b_ready",  32'(bus.b_ready),    32'd0);
    chk("rst_stall",    32'(bus.stall_req),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      $display("vec %0d: a_we=%0d a=%0d b_v=%0d b=%0d fl=%0d -> rf_we=%0d rf_waddr=%0d rf_wdata=%0h cnt=%0d rdy=%0d p=%0d%0d",
               i, vecs[i].a_we, vecs[i].a_addr, vecs[i].b_v, vecs[i].b_addr, vecs[i].fl,
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count, bus.b_ready,
               bus.pend_hit_1, bus.pend_hit_2);
      chk($sformatf("v%0d_rf_we", i),    32'(bus.rf_we),      32'(vecs[i].e_we));
      chk($sformatf("v%0d_rf_waddr", i), 32'(bus.rf_waddr),   32'(vecs[i].e_addr));
      chk($sformatf("v%0d_rf_wdata", i), bus.rf_wdata,        vecs[i].e_data);
      chk($sformatf("v%0d_count", i),    32'(bus.fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_b_ready", i),  32'(bus.b_ready),    32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_pend1", i),    32'(bus.pend_hit_1), 32'(vecs[i].e_p1));
      chk($sformatf("v%0d_pend2", i),    32'(bus.pend_hit_2), 32'(vecs[i].e_p2));
      chk($sformatf("v%0d_stall", i),    32'(bus.stall_req),  32'd0);
    end

    // Starve guard: one buffered entry, A busy for 11 more cycles, then one idle cycle.
    drive(idle);
    bus.a_we      = 1'b1;
    bus.a_waddr   = 13;
    bus.a_wdata   = 32'h1300;
    bus.b_valid   = 1'b1;
    bus.b_waddr   = 12;
    bus.b_wdata   = 32'h1212;
    bus.lu_addr_1 = 12;
    @(posedge clk);
    #1;
    chk("starve_push_count", 32'(bus.fifo_count), 32'd1);
    bus.b_valid = 1'b0;
    bus.a_waddr = 14;
    for (int k = 1; k <= 11; k++) begin
      bus.a_wdata = 32'(k);
      @(posedge clk);
      #1;
      $display("starve cycle %0d: stall_req=%0d rf_waddr=%0d cnt=%0d", k, bus.stall_req, bus.rf_waddr, bus.fifo_count);
      chk($sformatf("starve_k%0d_stall", k), 32'(bus.stall_req), 32'(GUARD && (k >= 9)));
    end
    chk("starve_pend_held", 32'(bus.pend_hit_1), 32'd1);
    chk("starve_rf_is_a",   32'(bus.rf_waddr),   32'd14);
    bus.a_we = 1'b0;
    @(posedge clk);
    #1;
    $display("starve release: rf_we=%0d rf_waddr=%0d rf_wdata=%0h stall_req=%0d", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_req);
    chk("starve_rel_we",    32'(bus.rf_we),      32'd1);
    chk("starve_rel_addr",  32'(bus.rf_waddr),   32'd12);
    chk("starve_rel_data",  bus.rf_wdata,        32'h1212);
    chk("starve_rel_stall", 32'(bus.stall_req),  32'd0);
    chk("starve_rel_count", 32'(bus.fifo_count), 32'd0);

    // Asynchronous reset while draining.
    bus.a_we    = 1'b1;
    bus.a_waddr = 15;
    bus.b_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.b_waddr = AW'(16 + j);
      bus.b_wdata = 32'(16 + j);
      @(posedge clk);
      #1;
    end
    bus.a_we      = 1'b0;
    bus.b_valid   = 1'b0;
    bus.lu_addr_1 = 17;
    @(posedge clk);
    #1;
    $display("drain before reset: rf_we=%0d rf_waddr=%0d cnt=%0d", bus.rf_we, bus.rf_waddr, bus.fifo_count);
    chk("drain_rf_we",    32'(bus.rf_we),      32'd1);
    chk("drain_rf_waddr", 32'(bus.rf_waddr),   32'd16);
    chk("drain_count",    32'(bus.fifo_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: rf_we=%0d cnt=%0d b_ready=%0d pend1=%0d", bus.rf_we, bus.fifo_count, bus.b_ready, bus.pend_hit_1);
    chk("arst_rf_we",   32'(bus.rf_we),      32'd0);
    chk("arst_rf_addr", 32'(bus.rf_waddr),   32'd0);
    chk("arst_count",   32'(bus.fifo_count), 32'd0);
    chk("arst_b_ready", 32'(bus.b_ready),    32'd0);
    chk("arst_pend1",   32'(bus.pend_hit_1), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_b_ready", 32'(bus.b_ready), 32'd1);
    chk("post_rst_rf_we",   32'(bus.rf_we),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
